// File: rtl/channel_group_accumulator_pkg.sv
// Shared constants and state encoding for the channel-group accumulator.
// Lane width and picture count mirror the adder-tree build constants.
package channel_group_accumulator_pkg;

  localparam int unsigned PICTURE_NUM    = 2;
  localparam int unsigned WIDTH_DATA_OUT = 16;
  localparam int unsigned LANES          = 2 * PICTURE_NUM;
  localparam int unsigned IN_W           = LANES * WIDTH_DATA_OUT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/channel_group_accumulator_if.sv
// Beat stream from the adder tree and finished-pixel stream toward the next stage.
interface channel_group_accumulator_if
  import channel_group_accumulator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32
);

  logic [IN_W-1:0]            data_in;
  logic                       valid_in;
  logic [LANES*ACC_WIDTH-1:0] data_out;
  logic                       valid_out;

  modport master (
    output data_in,
    output valid_in,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output data_out,
    output valid_out
  );

endinterface

// File: rtl/channel_group_accumulator_acc_lane.sv
// One accumulator lane: sign-extend the tree output, then overwrite or add.
// acc presents the post-beat sum so the top can capture a finished pixel on the same edge.
module acc_lane
  import channel_group_accumulator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             first,
  input  logic signed [WIDTH_DATA_OUT-1:0] din,
  output logic signed [ACC_WIDTH-1:0]      acc
);

  logic signed [ACC_WIDTH-1:0] din_ext;
  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;

  always_comb begin
    din_ext = {{(ACC_WIDTH - WIDTH_DATA_OUT){din[WIDTH_DATA_OUT-1]}}, din};
    acc_d   = first ? din_ext : acc_q + din_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_d;

endmodule

// File: rtl/channel_group_accumulator.sv
// Accumulates adder-tree beats over the configured channel groups per output pixel,
// counts pixels for a layer pass and reports completion to the convolution controller.
module channel_group_accumulator
  import channel_group_accumulator_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned GROUP_W   = 8,
  parameter int unsigned PIXEL_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GROUP_W-1:0]  cfg_group_num,
  input  logic [PIXEL_W-1:0]  cfg_pixel_num,
  channel_group_accumulator_if.slave bus,
  output logic                busy,
  output logic                done,
  output logic                drop_err
);

  state_e                     state_q;
  logic [GROUP_W-1:0]         gnum_q;
  logic [PIXEL_W-1:0]         pnum_q;
  logic [GROUP_W-1:0]         grp_cnt_q;
  logic [PIXEL_W-1:0]         pix_cnt_q;
  logic                       last_q;
  logic                       valid_out_q;
  logic                       done_q;
  logic                       busy_q;
  logic                       drop_err_q;
  logic [LANES*ACC_WIDTH-1:0] data_out_q;
  logic [LANES*ACC_WIDTH-1:0] sum_all;

  logic accept;
  logic first;
  logic grp_last;
  logic pix_last;

  always_comb begin
    accept   = (state_q == ST_RUN) && !last_q && bus.valid_in;
    first    = (grp_cnt_q == '0);
    grp_last = (grp_cnt_q == gnum_q - GROUP_W'(1));
    pix_last = (pix_cnt_q == pnum_q - PIXEL_W'(1));
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    acc_lane #(
      .ACC_WIDTH(ACC_WIDTH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (accept),
      .first(first),
      .din  (bus.data_in[k*WIDTH_DATA_OUT +: WIDTH_DATA_OUT]),
      .acc  (sum_all[k*ACC_WIDTH +: ACC_WIDTH])
    );
  end

  // The last pixel sets last_q; RUN is held one more cycle so valid_out precedes done
  // by exactly one cycle and busy falls together with done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnum_q      <= '0;
      pnum_q      <= '0;
      grp_cnt_q   <= '0;
      pix_cnt_q   <= '0;
      last_q      <= 1'b0;
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      data_out_q  <= '0;
    end else begin
      valid_out_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            gnum_q     <= (cfg_group_num == '0) ? GROUP_W'(1) : cfg_group_num;
            pnum_q     <= cfg_pixel_num;
            grp_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            last_q     <= 1'b0;
            drop_err_q <= bus.valid_in;
            if (cfg_pixel_num == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end else if (bus.valid_in) begin
            drop_err_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_q) begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            if (bus.valid_in) drop_err_q <= 1'b1;
          end else if (bus.valid_in) begin
            if (grp_last) begin
              grp_cnt_q   <= '0;
              pix_cnt_q   <= pix_cnt_q + PIXEL_W'(1);
              valid_out_q <= 1'b1;
              data_out_q  <= sum_all;
              if (pix_last) last_q <= 1'b1;
            end else begin
              grp_cnt_q <= grp_cnt_q + GROUP_W'(1);
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          if (bus.valid_in) drop_err_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign drop_err      = drop_err_q;

endmodule

// File: tb/tb_channel_group_accumulator.sv
// Directed bench for channel_group_accumulator with hand-computed per-lane sums.
module tb_channel_group_accumulator;
  import channel_group_accumulator_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned GW = 8;
  localparam int unsigned PW = 16;
  localparam int unsigned OW = LANES * AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [GW-1:0] cfg_g;
  logic [PW-1:0] cfg_p;
  logic          busy;
  logic          done;
  logic          drop_err;

  channel_group_accumulator_if #(.ACC_WIDTH(AW)) bus ();

  channel_group_accumulator #(
    .ACC_WIDTH(AW),
    .GROUP_W  (GW),
    .PIXEL_W  (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cfg_group_num(cfg_g),
    .cfg_pixel_num(cfg_p),
    .bus          (bus),
    .busy         (busy),
    .done         (done),
    .drop_err     (drop_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [OW-1:0] vo_q[$];
  int            vo_c[$];
  int            dn_c[$];
  logic          dn_busy[$];

  always @(negedge clk) begin
    cyc++;
    if (bus.valid_out) begin
      vo_q.push_back(bus.data_out);
      vo_c.push_back(cyc);
    end
    if (done) begin
      dn_c.push_back(cyc);
      dn_busy.push_back(busy);
    end
  end

  task automatic chk(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [OW-1:0] lanes(input int v, input bit sc);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < int'(LANES); k++) r[k*AW +: AW] = AW'(v * (sc ? k + 1 : 1));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v, input bit sc);
    bus.valid_in = 1'b1;
    for (int k = 0; k < int'(LANES); k++)
      bus.data_in[k*WIDTH_DATA_OUT +: WIDTH_DATA_OUT] = WIDTH_DATA_OUT'(v * (sc ? k + 1 : 1));
    tick();
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic go(input int g, input int p);
    cfg_g = GW'(g);
    cfg_p = PW'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_q();
    vo_q.delete();
    vo_c.delete();
    dn_c.delete();
    dn_busy.delete();
  endtask

  task automatic expect_pass(input string tag, input logic [OW-1:0] ev[$], input int spacing);
    chk({tag, " nvalid"}, OW'(vo_q.size()), OW'(ev.size()));
    for (int i = 0; i < ev.size() && i < vo_q.size(); i++) begin
      chk($sformatf("%s data%0d", tag, i), vo_q[i], ev[i]);
      if (spacing > 0 && i > 0) chk($sformatf("%s gap%0d", tag, i), OW'(vo_c[i] - vo_c[i-1]), OW'(spacing));
    end
    chk({tag, " ndone"}, OW'(dn_c.size()), OW'(1));
    if (dn_c.size() > 0) begin
      chk({tag, " busy@done"}, OW'(dn_busy[0]), OW'(0));
      if (vo_c.size() > 0) chk({tag, " done lag"}, OW'(dn_c[0] - vo_c[vo_c.size()-1]), OW'(1));
    end
    clear_q();
  endtask

  initial begin
    logic [OW-1:0] ev[$];
    int acc3;
    rst          = 1'b1;
    start        = 1'b0;
    cfg_g        = '0;
    cfg_p        = '0;
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst data_out", bus.data_out, '0);
    chk("rst valid_out", OW'(bus.valid_out), '0);
    chk("rst busy", OW'(busy), '0);
    chk("rst done", OW'(done), '0);
    chk("rst drop_err", OW'(drop_err), '0);

    // one group per pixel, identical lanes
    go(1, 3);
    chk("t1 busy", OW'(busy), OW'(1));
    beat(-5, 0); beat(1, 0); beat(7, 0);
    idle(4);
    ev = '{lanes(-5, 0), lanes(1, 0), lanes(7, 0)};
    expect_pass("t1", ev, 1);

    // four groups, back-to-back, second pixel overwrites without a clear bubble
    go(4, 2);
    beat(100, 1); beat(-50, 1); beat(25, 1); beat(0, 1);
    beat(1, 1); beat(1, 1); beat(1, 1); beat(1, 1);
    idle(4);
    ev = '{lanes(75, 1), lanes(4, 1)};
    expect_pass("t2", ev, 4);

    // three groups separated by random gaps
    go(3, 1);
    acc3 = 0;
    foreach (ev[i]) ev.delete(i);
    for (int i = 0; i < 3; i++) begin
      int v;
      v = (i == 0) ? 1000 : (i == 1) ? -3000 : 7000;
      acc3 += v;
      beat(v, 1);
      idle($urandom_range(0, 5));
    end
    idle(4);
    ev = '{lanes(acc3, 1)};
    expect_pass("t3", ev, 0);

    // most-negative lane value over the largest group count
    go(255, 1);
    for (int i = 0; i < 255; i++) beat(-32768, 0);
    idle(4);
    ev = '{lanes(-8355840, 0)};
    expect_pass("t4", ev, 0);

    // beat outside RUN, then an empty pass
    beat(55, 1);
    idle(1);
    chk("t5 drop_err set", OW'(drop_err), OW'(1));
    chk("t5 no valid", OW'(vo_q.size()), '0);
    go(1, 0);
    chk("t5 drop_err clr", OW'(drop_err), '0);
    chk("t5 done", OW'(done), OW'(1));
    idle(1);
    chk("t5 done pulse", OW'(done), '0);
    idle(2);
    ev = {};
    expect_pass("t5", ev, 0);

    // reset mid-pass, then a fresh pass with no residue
    go(4, 1);
    beat(10, 1); beat(20, 1);
    bus.valid_in = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6 rst data_out", bus.data_out, '0);
    chk("t6 rst busy", OW'(busy), '0);
    chk("t6 rst done", OW'(done), '0);
    idle(3);
    chk("t6 no done", OW'(dn_c.size()), '0);
    chk("t6 no valid", OW'(vo_q.size()), '0);
    clear_q();
    go(2, 1);
    beat(3, 1); beat(4, 1);
    idle(4);
    ev = '{lanes(7, 1)};
    expect_pass("t6", ev, 0);

    // group count of zero behaves as one
    go(0, 2);
    beat(9, 1); beat(-2, 1);
    idle(4);
    ev = '{lanes(9, 1), lanes(-2, 1)};
    expect_pass("t7", ev, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
